memory_access: RTL and testbench

//  MEMORY (_m) pipeline stage. Registers the execute-stage results (_e bundle) and performs word

---
 rtl/memory_access_pkg.sv | 33 +++
 rtl/memory_access_if.sv | 25 ++
 rtl/memory_access_dmem_req_fsm.sv | 145 ++++++++++++++
 rtl/memory_access.sv | 139 +++++++++++++
 tb/tb_memory_access.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_pkg
// Shared definitions for the memory (_m) pipeline stage: writeback-source
// encodings (common with execute and writeback), the bus FSM state type and
// small decode helpers used when an instruction is captured from execute.
// -----------------------------------------------------------------------------
package memory_access_pkg;

  // Writeback source select, as produced by execute
  localparam logic [1:0] RD_SRC_ALU = 2'b00;
  localparam logic [1:0] RD_SRC_MEM = 2'b01;
  localparam logic [1:0] RD_SRC_PC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // A store, or a register write that takes its value from memory
  function automatic logic is_mem_access(input logic       mem_write,
                                         input logic       rd_write,
                                         input logic [1:0] rd_src);
    return mem_write | (rd_write & (rd_src == RD_SRC_MEM));
  endfunction

  // Word accesses only: any set byte-offset bit is an error
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// -----------------------------------------------------------------------------
// memory_access_if
// Word-wide data-memory bus with req/gnt request handshake and rvalid return.
//   req    master->slave  request, held until gnt
//   we     master->slave  1 = store
//   addr   master->slave  word address
//   wdata  master->slave  store data
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  load data valid (never in the same cycle as its gnt)
//   rdata  slave->master  load data
// -----------------------------------------------------------------------------
interface memory_access_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/memory_access_dmem_req_fsm.sv
// -----------------------------------------------------------------------------
// memory_access_dmem_req_fsm
// Bus sequencing for the memory stage: state register, kill bit, busy-cycle
// timeout counter and the registered bus request.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   capture         the _m registers load from execute at this edge
//   flush           kill the instruction in _m
//   access_e        captured instruction performs a bus access
//   misaligned_e    captured address is not word aligned
//   store_m         instruction in _m is a store
//   gnt, rvalid     bus responses
//   busy            access outstanding (REQ or RESP), from registered state
//   req             registered bus request
//   kill            instruction in _m was flushed while its access drains
//   err             misaligned or timed-out access
//   load_rdata      load read_data_m from the bus at this edge
//   zero_rdata      clear read_data_m at this edge (timeout)
//   clr_m           clear all _m registers at this edge
// -----------------------------------------------------------------------------
module memory_access_dmem_req_fsm
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic capture,
  input  logic flush,
  input  logic access_e,
  input  logic misaligned_e,
  input  logic store_m,
  input  logic gnt,
  input  logic rvalid,
  output logic busy,
  output logic req,
  output logic kill,
  output logic err,
  output logic load_rdata,
  output logic zero_rdata,
  output logic clr_m
);

  localparam logic        TO_EN   = (TIMEOUT_CYC != 0);
  // Counter value during the last permitted busy cycle
  localparam logic [31:0] TO_LAST = TO_EN ? (TIMEOUT_CYC - 32'd1) : 32'd0;

  mem_state_e  state, state_nxt;
  logic        kill_nxt;
  logic        err_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        req_q;
  logic        done;
  logic        kill_eff;

  always_comb begin
    state_nxt  = state;
    kill_nxt   = kill;
    err_nxt    = err;
    cnt_nxt    = cnt;
    load_rdata = 1'b0;
    zero_rdata = 1'b0;
    clr_m      = 1'b0;
    done       = 1'b0;
    kill_eff   = kill | flush;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (flush) begin
          state_nxt = ST_IDLE;
          kill_nxt  = 1'b0;
          err_nxt   = 1'b0;
          clr_m     = 1'b1;
        end else if (capture) begin
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = ST_IDLE;
          if (access_e) begin
            if (misaligned_e) begin
              state_nxt = ST_DONE;
              err_nxt   = 1'b1;
            end else begin
              state_nxt = ST_REQ;
            end
          end
        end
      end

      ST_REQ, ST_RESP: begin
        cnt_nxt  = cnt + 32'd1;
        kill_nxt = kill_eff;
        if (state == ST_REQ) begin
          if (gnt) begin
            if (store_m) done = 1'b1;
            else         state_nxt = ST_RESP;
          end
        end else if (rvalid) begin
          load_rdata = 1'b1;
          done       = 1'b1;
        end

        // A bus event completing the access in the last cycle wins over the timeout
        if (!done && TO_EN && (cnt == TO_LAST)) begin
          done       = 1'b1;
          err_nxt    = 1'b1;
          zero_rdata = 1'b1;
        end

        // A flushed instruction retires straight to IDLE with its _m state wiped
        if (done) begin
          if (kill_eff) begin
            state_nxt = ST_IDLE;
            kill_nxt  = 1'b0;
            err_nxt   = 1'b0;
            clr_m     = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      kill  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      err   <= err_nxt;
      cnt   <= cnt_nxt;
      req_q <= (state_nxt == ST_REQ);
    end
  end

  assign busy = (state == ST_REQ) || (state == ST_RESP);
  assign req  = req_q;

endmodule

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// Memory (_m) pipeline stage. Registers the execute bundle, performs word
// loads/stores on the data bus and hands the results to writeback. alu_res_m
// is a plain register so it can be forwarded the cycle after capture.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   *_e                      execute-stage bundle
//   stall_m, flush_m         hazard controls (hold / kill the _m instruction)
//   busy_m                   bus access outstanding; hazard unit stalls on it
//   *_m                      registered copies to writeback (masked when killed)
//   read_data_m              load data, valid when busy_m=0
//   err_m                    misaligned or timed-out access
//   dmem                     data bus (master side)
// -----------------------------------------------------------------------------
module memory_access
  import memory_access_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write_e,
  input  logic            rd_write_e,
  input  logic [1:0]      rd_write_src_e,
  input  logic            mem_write_e,
  input  logic [4:0]      rd_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] alu_res_e,
  input  logic [XLEN-1:0] mem_data_e,
  input  logic            stall_m,
  input  logic            flush_m,
  output logic            busy_m,
  output logic            pc_write_m,
  output logic            rd_write_m,
  output logic [1:0]      rd_write_src_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] pc_m,
  output logic [XLEN-1:0] alu_res_m,
  output logic [XLEN-1:0] read_data_m,
  output logic            err_m,
  memory_access_if.master dmem
);

  logic            pc_write_q;
  logic            rd_write_q;
  logic [1:0]      rd_write_src_q;
  logic            mem_write_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] alu_res_q;
  logic [XLEN-1:0] mem_data_q;
  logic [XLEN-1:0] read_data_q;

  logic capture;
  logic kill;
  logic err;
  logic load_rdata;
  logic zero_rdata;
  logic clr_m;

  assign capture = ~stall_m & ~flush_m;

  memory_access_dmem_req_fsm #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .flush        (flush_m),
    .access_e     (is_mem_access(mem_write_e, rd_write_e, rd_write_src_e)),
    .misaligned_e (is_misaligned(alu_res_e[1:0])),
    .store_m      (mem_write_q),
    .gnt          (dmem.gnt),
    .rvalid       (dmem.rvalid),
    .busy         (busy_m),
    .req          (dmem.req),
    .kill         (kill),
    .err          (err),
    .load_rdata   (load_rdata),
    .zero_rdata   (zero_rdata),
    .clr_m        (clr_m)
  );

  // Execute -> memory stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_write_q     <= 1'b0;
      rd_write_q     <= 1'b0;
      rd_write_src_q <= RD_SRC_ALU;
      mem_write_q    <= 1'b0;
      rd_q           <= '0;
      pc_q           <= '0;
      alu_res_q      <= '0;
      mem_data_q     <= '0;
      read_data_q    <= '0;
    end else if (clr_m) begin
      pc_write_q     <= 1'b0;
      rd_write_q     <= 1'b0;
      rd_write_src_q <= RD_SRC_ALU;
      mem_write_q    <= 1'b0;
      rd_q           <= '0;
      pc_q           <= '0;
      alu_res_q      <= '0;
      mem_data_q     <= '0;
      read_data_q    <= '0;
    end else begin
      if (capture) begin
        pc_write_q     <= pc_write_e;
        rd_write_q     <= rd_write_e;
        rd_write_src_q <= rd_write_src_e;
        mem_write_q    <= mem_write_e;
        rd_q           <= rd_e;
        pc_q           <= pc_e;
        alu_res_q      <= alu_res_e;
        mem_data_q     <= mem_data_e;
      end
      if (zero_rdata)      read_data_q <= '0;
      else if (load_rdata) read_data_q <= dmem.rdata;
    end
  end

  // A killed instruction must not write back, redirect the pc or raise an error
  assign pc_write_m     = pc_write_q & ~kill;
  assign rd_write_m     = rd_write_q & ~kill;
  assign err_m          = err & ~kill;
  assign rd_write_src_m = rd_write_src_q;
  assign rd_m           = rd_q;
  assign pc_m           = pc_q;
  assign alu_res_m      = alu_res_q;
  assign read_data_m    = read_data_q;

  // The _m registers are held by stall_m while busy, so the bus fields stay stable until gnt
  assign dmem.we    = mem_write_q;
  assign dmem.addr  = alu_res_q;
  assign dmem.wdata = mem_data_q;

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
// Directed bench for memory_access. dut0 runs without a timeout; dut_t shares
// the execute bundle, has TIMEOUT_CYC=4 and its own hazard controls and bus.
// -----------------------------------------------------------------------------
module tb_memory_access;

  logic        clk;
  logic        rst;
  logic        pc_write_e, rd_write_e, mem_write_e;
  logic [1:0]  rd_write_src_e;
  logic [4:0]  rd_e;
  logic [31:0] pc_e, alu_res_e, mem_data_e;

  logic        stall_m, flush_m;
  logic        busy_m, pc_write_m, rd_write_m, err_m;
  logic [1:0]  rd_write_src_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_m, alu_res_m, read_data_m;

  logic        stall_t, flush_t;
  logic        busy_t, pc_write_t, rd_write_t, err_t;
  logic [1:0]  rd_write_src_t;
  logic [4:0]  rd_t;
  logic [31:0] pc_t, alu_res_t, read_data_t;

  int n_tests;
  int n_fail;
  int viol_cnt;
  int busy_cnt;

  memory_access_if #(.XLEN(32)) bus0 ();
  memory_access_if #(.XLEN(32)) bus_t ();

  memory_access #(.XLEN(32), .TIMEOUT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .pc_write_e(pc_write_e), .rd_write_e(rd_write_e), .rd_write_src_e(rd_write_src_e),
    .mem_write_e(mem_write_e), .rd_e(rd_e), .pc_e(pc_e), .alu_res_e(alu_res_e),
    .mem_data_e(mem_data_e), .stall_m(stall_m), .flush_m(flush_m), .busy_m(busy_m),
    .pc_write_m(pc_write_m), .rd_write_m(rd_write_m), .rd_write_src_m(rd_write_src_m),
    .rd_m(rd_m), .pc_m(pc_m), .alu_res_m(alu_res_m), .read_data_m(read_data_m),
    .err_m(err_m), .dmem(bus0)
  );

  memory_access #(.XLEN(32), .TIMEOUT_CYC(4)) dut_t (
    .clk(clk), .rst(rst),
    .pc_write_e(pc_write_e), .rd_write_e(rd_write_e), .rd_write_src_e(rd_write_src_e),
    .mem_write_e(mem_write_e), .rd_e(rd_e), .pc_e(pc_e), .alu_res_e(alu_res_e),
    .mem_data_e(mem_data_e), .stall_m(stall_t), .flush_m(flush_t), .busy_m(busy_t),
    .pc_write_m(pc_write_t), .rd_write_m(rd_write_t), .rd_write_src_m(rd_write_src_t),
    .rd_m(rd_t), .pc_m(pc_t), .alu_res_m(alu_res_t), .read_data_m(read_data_t),
    .err_m(err_t), .dmem(bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A capture edge must never arrive while an access is outstanding
  always @(negedge clk) begin
    if (!rst && !stall_m && !flush_m && busy_m) begin
      viol_cnt++;
      $display("[TB] dut0 capture edge while busy at %0t", $time);
    end
    if (!rst && !stall_t && !flush_t && busy_t) begin
      viol_cnt++;
      $display("[TB] dut_t capture edge while busy at %0t", $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_e(input logic pcw, input logic rdw, input logic [1:0] src,
                       input logic mw, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] data);
    pc_write_e     = pcw;
    rd_write_e     = rdw;
    rd_write_src_e = src;
    mem_write_e    = mw;
    rd_e           = rd;
    pc_e           = pc;
    alu_res_e      = alu;
    mem_data_e     = data;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    viol_cnt = 0;
    busy_cnt = 0;
    rst      = 1'b1;
    stall_m  = 1'b1;
    flush_m  = 1'b0;
    stall_t  = 1'b1;
    flush_t  = 1'b0;
    set_e(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    bus0.gnt    = 1'b0;
    bus0.rvalid = 1'b0;
    bus0.rdata  = 32'h0;
    bus_t.gnt    = 1'b0;
    bus_t.rvalid = 1'b0;
    bus_t.rdata  = 32'h0;

    // Reset state
    step();
    step();
    chk1("rst_busy", busy_m, 1'b0);
    chk1("rst_req", bus0.req, 1'b0);
    chk1("rst_err", err_m, 1'b0);
    chk32("rst_alu_res", alu_res_m, 32'h0);
    chk32("rst_read_data", read_data_m, 32'h0);
    chk32("rst_addr", bus0.addr, 32'h0);
    rst = 1'b0;
    step();

    // 1: store 0xDEADBEEF to 0x100, granted in its first REQ cycle
    set_e(1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 32'h1000, 32'h100, 32'hDEADBEEF);
    bus0.gnt = 1'b1;
    stall_m  = 1'b0;
    step();
    stall_m = 1'b1;
    chk1("st_busy_first", busy_m, 1'b1);
    chk1("st_req", bus0.req, 1'b1);
    chk1("st_we", bus0.we, 1'b1);
    chk32("st_addr", bus0.addr, 32'h100);
    chk32("st_wdata", bus0.wdata, 32'hDEADBEEF);
    step();
    bus0.gnt = 1'b0;
    chk1("st_busy_after", busy_m, 1'b0);
    chk1("st_req_after", bus0.req, 1'b0);
    chk1("st_err", err_m, 1'b0);

    // 3: ALU result 0x42, no bus access
    set_e(1'b0, 1'b1, 2'b00, 1'b0, 5'd5, 32'h2000, 32'h42, 32'h0);
    stall_m = 1'b0;
    step();
    stall_m = 1'b1;
    chk32("alu_res", alu_res_m, 32'h42);
    chk1("alu_busy", busy_m, 1'b0);
    chk1("alu_req", bus0.req, 1'b0);
    chk1("alu_rd_write", rd_write_m, 1'b1);
    chk32("alu_rd", 32'(rd_m), 32'd5);
    step();
    chk1("alu_busy_later", busy_m, 1'b0);

    // 2: load from 0x200, gnt in the 3rd busy cycle, rvalid two cycles later
    set_e(1'b0, 1'b1, 2'b01, 1'b0, 5'd7, 32'h3000, 32'h200, 32'h0);
    stall_m = 1'b0;
    step();
    stall_m  = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      bus0.gnt    = (k == 3);
      bus0.rvalid = (k == 5);
      bus0.rdata  = (k == 5) ? 32'h12345678 : 32'h0;
      if (busy_m) busy_cnt++;
      if (k == 1) begin
        chk1("ld_req", bus0.req, 1'b1);
        chk1("ld_we", bus0.we, 1'b0);
        chk32("ld_addr", bus0.addr, 32'h200);
        chk32("ld_fwd_alu_res", alu_res_m, 32'h200);
      end
      if (k == 3) chk1("ld_req_held", bus0.req, 1'b1);
      if (k == 4) chk1("ld_req_dropped", bus0.req, 1'b0);
      if (k == 5) chk32("ld_data_not_early", read_data_m, 32'h0);
      step();
    end
    bus0.gnt    = 1'b0;
    bus0.rvalid = 1'b0;
    chk32("ld_busy_cycles", 32'(busy_cnt), 32'd5);
    chk32("ld_read_data", read_data_m, 32'h12345678);
    chk32("ld_src", 32'(rd_write_src_m), 32'd1);
    chk1("ld_rd_write", rd_write_m, 1'b1);
    chk32("ld_rd", 32'(rd_m), 32'd7);

    // 4: misaligned load to 0x203
    set_e(1'b0, 1'b1, 2'b01, 1'b0, 5'd3, 32'h3004, 32'h203, 32'h0);
    stall_m = 1'b0;
    step();
    stall_m = 1'b1;
    chk1("mis_err", err_m, 1'b1);
    chk1("mis_busy", busy_m, 1'b0);
    chk1("mis_req", bus0.req, 1'b0);
    step();
    chk1("mis_req_later", bus0.req, 1'b0);
    chk1("mis_err_held", err_m, 1'b1);

    // 5: flush during RESP of a load
    set_e(1'b1, 1'b1, 2'b01, 1'b0, 5'd9, 32'h4000, 32'h300, 32'h0);
    bus0.gnt = 1'b1;
    stall_m  = 1'b0;
    step();
    stall_m = 1'b1;
    step();
    bus0.gnt = 1'b0;
    chk1("fl_busy_resp", busy_m, 1'b1);
    chk1("fl_rd_write_before", rd_write_m, 1'b1);
    chk1("fl_pc_write_before", pc_write_m, 1'b1);
    chk1("fl_err_cleared", err_m, 1'b0);
    flush_m = 1'b1;
    step();
    flush_m = 1'b0;
    chk1("fl_busy_draining", busy_m, 1'b1);
    chk1("fl_rd_write_masked", rd_write_m, 1'b0);
    chk1("fl_pc_write_masked", pc_write_m, 1'b0);
    bus0.rvalid = 1'b1;
    bus0.rdata  = 32'hCAFEF00D;
    step();
    bus0.rvalid = 1'b0;
    chk1("fl_busy_done", busy_m, 1'b0);
    chk1("fl_rd_write_clr", rd_write_m, 1'b0);
    chk32("fl_rd_clr", 32'(rd_m), 32'd0);
    chk32("fl_pc_clr", pc_m, 32'h0);
    chk32("fl_alu_res_clr", alu_res_m, 32'h0);
    chk32("fl_src_clr", 32'(rd_write_src_m), 32'd0);
    chk32("fl_read_data_clr", read_data_m, 32'h0);
    chk1("fl_req", bus0.req, 1'b0);

    // Flush while idle clears the _m registers
    set_e(1'b0, 1'b1, 2'b00, 1'b0, 5'd4, 32'h5000, 32'h77, 32'h0);
    stall_m = 1'b0;
    step();
    stall_m = 1'b1;
    chk32("idle_cap_alu", alu_res_m, 32'h77);
    flush_m = 1'b1;
    step();
    flush_m = 1'b0;
    chk32("idle_fl_alu", alu_res_m, 32'h0);
    chk1("idle_fl_rd_write", rd_write_m, 1'b0);
    chk32("idle_fl_rd", 32'(rd_m), 32'd0);

    // 6a: timeout with gnt never given (dut_t, TIMEOUT_CYC=4)
    set_e(1'b0, 1'b1, 2'b01, 1'b0, 5'd2, 32'h6000, 32'h400, 32'h0);
    stall_t = 1'b0;
    step();
    stall_t  = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      if (busy_t) busy_cnt++;
      if (k == 1) chk1("to_err_early", err_t, 1'b0);
      if (k == 4) chk1("to_req_last", bus_t.req, 1'b1);
      step();
    end
    chk32("to_busy_cycles", 32'(busy_cnt), 32'd4);
    chk1("to_err", err_t, 1'b1);
    chk1("to_req_low", bus_t.req, 1'b0);
    chk1("to_busy", busy_t, 1'b0);
    chk32("to_read_data", read_data_t, 32'h0);
    bus_t.gnt = 1'b1;
    step();
    bus_t.gnt = 1'b0;
    chk1("to_late_gnt_err", err_t, 1'b1);
    chk1("to_late_gnt_busy", busy_t, 1'b0);

    // 6b: asynchronous reset in the middle of a REQ
    set_e(1'b0, 1'b1, 2'b01, 1'b0, 5'd6, 32'h7000, 32'h500, 32'h0);
    stall_m = 1'b0;
    step();
    stall_m = 1'b1;
    chk1("arst_req_before", bus0.req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_req", bus0.req, 1'b0);
    chk1("arst_busy", busy_m, 1'b0);
    chk1("arst_rd_write", rd_write_m, 1'b0);
    chk32("arst_alu_res", alu_res_m, 32'h0);
    chk32("arst_addr", bus0.addr, 32'h0);
    chk1("arst_err_t", err_t, 1'b0);
    rst = 1'b0;
    step();

    chk32("protocol_violations", 32'(viol_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
